// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait sequencing for the five-stage RV32 pipe.
// Optional EX operand forwarding is enabled by defining HAZARD_FORWARD_EN.
module hazard_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_reg_wen_i,
   input  logic        id_mem_ren_i,
   input  logic        ex_redirect_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ready_i,
   output logic        stall_if_o,
   output logic        stall_id_o,
   output logic        flush_if_o,
   output logic        flush_id_o,
   output logic        freeze_o,
   output logic [1:0]  fwd_a_o,
   output logic [1:0]  fwd_b_o,
   output logic [31:0] stall_cnt_o
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             wen;
      logic             is_load;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             rs1_used;
      logic             rs2_used;
   } shadow_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   mem_state_e       state_q, state_d;
   shadow_t          ex_q, ex_d;
   shadow_t          mem_q, mem_d;
   shadow_t          wb_q, wb_d;
   logic [XLEN-1:0]  cnt_q, cnt_d;
   shadow_t          id_s;

   logic             freeze_c;
   logic             load_use_c;
   logic             hit_ex_c;
   logic             hit_mem_c;
   logic             stall_if_c;
   logic             stall_id_c;
   logic             flush_if_c;
   logic             flush_id_c;
   logic [FWD_W-1:0] fwd_a_c;
   logic [FWD_W-1:0] fwd_b_c;
   logic             unused_shadow;

   // A stage is a hazard source only if it really writes a non-x0 register.
   function automatic logic produces(input shadow_t s);
      return s.valid && s.wen && (s.rd != '0);
   endfunction

   function automatic logic src_hit(input shadow_t prod, input logic [REG_W-1:0] rs,
                                    input logic used);
      return produces(prod) && used && (rs == prod.rd);
   endfunction

   assign id_s = '{valid:    id_valid_i,
                   rd:       id_rd_i,
                   wen:      id_reg_wen_i,
                   is_load:  id_mem_ren_i,
                   rs1:      id_rs1_i,
                   rs2:      id_rs2_i,
                   rs1_used: id_rs1_used_i,
                   rs2_used: id_rs2_used_i};

   // Memory wait state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory wait next state and freeze
   always_comb begin
      state_d  = state_q;
      freeze_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dmem_req_i && !dmem_ready_i) begin
               state_d  = ST_WAIT;
               freeze_c = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dmem_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               freeze_c = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign hit_ex_c  = src_hit(ex_q, id_rs1_i, id_rs1_used_i) ||
                      src_hit(ex_q, id_rs2_i, id_rs2_used_i);
   assign hit_mem_c = src_hit(mem_q, id_rs1_i, id_rs1_used_i) ||
                      src_hit(mem_q, id_rs2_i, id_rs2_used_i);

`ifdef HAZARD_FORWARD_EN
   // MEM result wins over WB; a load still in MEM never forwards.
   function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] rs, input logic used,
                                                input shadow_t mem_s, input shadow_t wb_s);
      if (src_hit(mem_s, rs, used) && !mem_s.is_load) begin
         return FWD_W'(1);
      end else if (src_hit(wb_s, rs, used)) begin
         return FWD_W'(2);
      end
      return FWD_W'(0);
   endfunction

   assign load_use_c = id_valid_i && ex_q.is_load && hit_ex_c;
   assign fwd_a_c    = ex_q.valid ? fwd_sel(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q) : '0;
   assign fwd_b_c    = ex_q.valid ? fwd_sel(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q) : '0;
`else
   // Without forwarding any in-flight producer ahead of WB blocks the consumer.
   assign load_use_c = id_valid_i && (hit_ex_c || hit_mem_c);
   assign fwd_a_c    = '0;
   assign fwd_b_c    = '0;
`endif

   // Stall/flush priority: freeze, then redirect, then load-use
   always_comb begin
      stall_if_c = 1'b0;
      stall_id_c = 1'b0;
      flush_if_c = 1'b0;
      flush_id_c = 1'b0;
      if (freeze_c) begin
         stall_if_c = 1'b0;
      end else if (ex_redirect_i) begin
         flush_if_c = 1'b1;
         flush_id_c = 1'b1;
      end else if (load_use_c) begin
         stall_if_c = 1'b1;
         stall_id_c = 1'b1;
         flush_id_c = 1'b1;
      end
   end

   // Shadow stage advance, held as a whole while frozen
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!freeze_c) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = id_s;
         if (!id_valid_i || stall_id_c || flush_id_c) begin
            ex_d = '0;
         end
      end
   end

   assign cnt_d = (stall_if_c || freeze_c) ? cnt_q + XLEN'(1) : cnt_q;

   // Shadow pipe and stall counter registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   // Some shadow fields are only consumed in one build flavour.
   assign unused_shadow = ^{ex_q, mem_q, wb_q};

   assign stall_if_o  = stall_if_c;
   assign stall_id_o  = stall_id_c;
   assign flush_if_o  = flush_if_c;
   assign flush_id_o  = flush_id_c;
   assign freeze_o    = freeze_c;
   assign fwd_a_o     = fwd_a_c;
   assign fwd_b_o     = fwd_b_c;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: hand-derived per-cycle expectations for each
// instruction sequence, compared mid-cycle; follows HAZARD_FORWARD_EN if defined.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wen;
      logic       ld;
   } ins_t;

   typedef struct packed {
      logic [4:0]  flags;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] cnt;
   } exp_t;

   // flags = {stall_if, stall_id, flush_if, flush_id, freeze}
   localparam logic [4:0] OK = 5'b00000;
   localparam logic [4:0] LU = 5'b11010;
   localparam logic [4:0] RD = 5'b00110;
   localparam logic [4:0] FZ = 5'b00001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   ins_t        id  = '0;
   logic        redir = 1'b0;
   logic        dreq  = 1'b0;
   logic        drdy  = 1'b0;
   logic        stall_if, stall_id, flush_if, flush_id, freeze;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cnt;

   exp_t        sb_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          cyc_no = 0;
   logic [31:0] exp_cnt = '0;

   hazard_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_valid_i    (id.v),
      .id_rs1_i      (id.rs1),
      .id_rs2_i      (id.rs2),
      .id_rs1_used_i (id.u1),
      .id_rs2_used_i (id.u2),
      .id_rd_i       (id.rd),
      .id_reg_wen_i  (id.wen),
      .id_mem_ren_i  (id.ld),
      .ex_redirect_i (redir),
      .dmem_req_i    (dreq),
      .dmem_ready_i  (drdy),
      .stall_if_o    (stall_if),
      .stall_id_o    (stall_id),
      .flush_if_o    (flush_if),
      .flush_id_o    (flush_id),
      .freeze_o      (freeze),
      .fwd_a_o       (fwd_a),
      .fwd_b_o       (fwd_b),
      .stall_cnt_o   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc_no, obs, exp);
      end
   endtask

   function automatic ins_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd, input logic ld);
      ins_t i;
      i = '{v: 1'b1, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, wen: 1'b1, ld: ld};
      return i;
   endfunction

   // Drive one cycle of stimulus and queue what the outputs must be in it.
   task automatic cyc(input ins_t i, input logic r, input logic q, input logic y,
                      input logic [4:0] f, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      @(posedge clk);
      #1;
      id    = i;
      redir = r;
      dreq  = q;
      drdy  = y;
      e     = '{flags: f, fa: fa, fb: fb, cnt: exp_cnt};
      sb_q.push_back(e);
      if (f[4] || f[0]) exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic drain();
      repeat (3) cyc('0, 1'b0, 1'b0, 1'b0, OK, 2'b00, 2'b00);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         cyc_no++;
         check("stall_if",  32'(stall_if),  32'(e.flags[4]));
         check("stall_id",  32'(stall_id),  32'(e.flags[3]));
         check("flush_if",  32'(flush_if),  32'(e.flags[2]));
         check("flush_id",  32'(flush_id),  32'(e.flags[1]));
         check("freeze",    32'(freeze),    32'(e.flags[0]));
         check("fwd_a",     32'(fwd_a),     32'(e.fa));
         check("fwd_b",     32'(fwd_b),     32'(e.fb));
         check("stall_cnt", stall_cnt,      e.cnt);
      end
   end

   initial begin
      ins_t add5, sub6, lw7, add8, addi0, add1, c65, nop;
      add5  = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0);
      sub6  = mk(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b0);
      lw7   = mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
      add8  = mk(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
      addi0 = mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      add1  = mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b0);
      c65   = mk(5'd3, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
      nop   = '0;

      // reset state
      cyc(nop, 1'b0, 1'b0, 1'b0, OK, 2'b00, 2'b00);
      @(negedge clk);
      #1 rst = 1'b0;

      // add x5 ; sub x6,x5,x3
`ifdef HAZARD_FORWARD_EN
      cyc(add5, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(sub6, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(nop,  0, 0, 0, OK, 2'b01, 2'b00);
`else
      cyc(add5, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(sub6, 0, 0, 0, LU, 2'b00, 2'b00);
      cyc(sub6, 0, 0, 0, LU, 2'b00, 2'b00);
      cyc(sub6, 0, 0, 0, OK, 2'b00, 2'b00);
`endif
      drain();

      // lw x7 ; add x8,x7,x7
`ifdef HAZARD_FORWARD_EN
      cyc(lw7,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add8, 0, 0, 0, LU, 2'b00, 2'b00);
      cyc(add8, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(nop,  0, 0, 0, OK, 2'b10, 2'b10);
`else
      cyc(lw7,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add8, 0, 0, 0, LU, 2'b00, 2'b00);
      cyc(add8, 0, 0, 0, LU, 2'b00, 2'b00);
      cyc(add8, 0, 0, 0, OK, 2'b00, 2'b00);
`endif
      drain();

      // two producers of x5, consumer on rs2: MEM wins over WB
`ifdef HAZARD_FORWARD_EN
      cyc(add5, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add5, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(c65,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(nop,  0, 0, 0, OK, 2'b00, 2'b01);
`else
      cyc(add5, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add5, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(c65,  0, 0, 0, LU, 2'b00, 2'b00);
      cyc(c65,  0, 0, 0, LU, 2'b00, 2'b00);
      cyc(c65,  0, 0, 0, OK, 2'b00, 2'b00);
`endif
      drain();

      // redirect overrides a pending load-use
      cyc(lw7,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add8, 1, 0, 0, RD, 2'b00, 2'b00);
      cyc(nop,  0, 0, 0, OK, 2'b00, 2'b00);
      drain();

      // 3-cycle dmem wait over redirect and load-use, load-use re-evaluated after
      cyc(lw7,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add8, 1, 1, 0, FZ, 2'b00, 2'b00);
      cyc(add8, 1, 1, 0, FZ, 2'b00, 2'b00);
      cyc(add8, 1, 1, 0, FZ, 2'b00, 2'b00);
      cyc(add8, 0, 1, 1, LU, 2'b00, 2'b00);
      cyc(nop,  0, 0, 0, OK, 2'b00, 2'b00);
      drain();

      // x0 never stalls or forwards
      cyc(addi0, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add1,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(nop,   0, 0, 0, OK, 2'b00, 2'b00);
      drain();

      // asynchronous reset in WAIT with a load-use consumer in ID
      cyc(lw7,  0, 0, 0, OK, 2'b00, 2'b00);
      cyc(add8, 0, 1, 0, FZ, 2'b00, 2'b00);
      cyc(add8, 0, 1, 0, FZ, 2'b00, 2'b00);
      @(negedge clk);
      #2;
      rst  = 1'b1;
      dreq = 1'b0;
      #1;
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_freeze",    32'(freeze),   32'd0);
      check("rst_stall_if",  32'(stall_if), 32'd0);
      check("rst_flush_id",  32'(flush_id), 32'd0);
      check("rst_fwd",       32'({fwd_a, fwd_b}), 32'd0);
      exp_cnt = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      // counting restarts from zero after reset
      cyc(add8, 0, 0, 0, OK, 2'b00, 2'b00);
      cyc(nop,  0, 1, 0, FZ, 2'b00, 2'b00);
      cyc(nop,  0, 1, 1, OK, 2'b00, 2'b00);
      cyc(nop,  0, 0, 0, OK, 2'b00, 2'b00);

      repeat (2) @(negedge clk);
      #1;
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
